// File: rtl/decode_pkg.sv
// Shared types for the decode-to-execute stage: control bundle, ALU op codes,
// stage state enum and the bubble counter width.
package decode_pkg;

    typedef struct packed {
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       mem_to_reg;
        logic       alu_reg_dest;
        logic       is_branch;
        logic       is_immediate;
        logic [1:0] alu_op;
        logic [5:0] funct;
    } ctrl_t;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_BR    = 2'b11;

    typedef enum logic {D_RUN, D_BUBBLE} dstate_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Wide enough for up to 3 bubbles per load-use hazard.
    localparam int BUB_CNT_W = 2;

endpackage

// File: rtl/decode_hazard_unit.sv
// Load-use hazard detection between the held instruction (a load) and the
// incoming one. Register 0 never produces a hazard.
module decode_hazard_unit #(
    parameter int REG_IDX_W = 5
) (
    input  logic                 in_valid,
    input  logic [REG_IDX_W-1:0] in_rega,
    input  logic [REG_IDX_W-1:0] in_regb,
    input  logic                 in_is_immediate,
    input  logic                 out_valid,
    input  logic [REG_IDX_W-1:0] out_regd,
    input  logic                 out_mem_r_en,
    output logic                 hazard
);

    logic load_held;
    logic match_a;
    logic match_b;

    // regb only matters when the instruction really reads it (not an immediate form).
    assign load_held = in_valid & out_valid & out_mem_r_en & (out_regd != '0);
    assign match_a   = (out_regd == in_rega);
    assign match_b   = (out_regd == in_regb) & ~in_is_immediate;
    assign hazard    = load_held & (match_a | match_b);

endmodule

// File: rtl/decode_pipe_stage.sv
// Decode-to-execute pipeline slot with valid/ready handshake and load-use bubbles.
// Optional writeback bypass on capture: define DECODE_WB_BYPASS_EN.
module decode_pipe_stage
    import decode_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int REG_IDX_W        = 5,
    parameter int IMM_W            = 16,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [XLEN-1:0]      in_rega_data,
    input  logic [XLEN-1:0]      in_regb_data,
    input  logic [IMM_W-1:0]     in_imm,
    input  logic [REG_IDX_W-1:0] in_rega,
    input  logic [REG_IDX_W-1:0] in_regb,
    input  logic [REG_IDX_W-1:0] in_regd,
    input  ctrl_t                in_ctrl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [XLEN-1:0]      out_rega_data,
    output logic [XLEN-1:0]      out_regb_data,
    output logic [XLEN-1:0]      out_imm,
    output logic [REG_IDX_W-1:0] out_rega,
    output logic [REG_IDX_W-1:0] out_regb,
    output logic [REG_IDX_W-1:0] out_regd,
    output ctrl_t                out_ctrl,
    output logic                 hazard_stall,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_regd,
    input  logic [XLEN-1:0]      wb_data
);

    localparam logic [BUB_CNT_W-1:0] BUB_RELOAD = BUB_CNT_W'(LOAD_USE_BUBBLES - 1);
    localparam logic [BUB_CNT_W-1:0] BUB_ONE    = BUB_CNT_W'(1);

    dstate_t               state;
    logic [BUB_CNT_W-1:0]  bub_cnt;
    logic                  hazard;
    logic                  adv;
    logic                  accept;
    logic [XLEN-1:0]       rega_cap;
    logic [XLEN-1:0]       regb_cap;
    logic [XLEN-1:0]       imm_ext;

    decode_hazard_unit #(
        .REG_IDX_W (REG_IDX_W)
    ) u_hazard (
        .in_valid        (in_valid),
        .in_rega         (in_rega),
        .in_regb         (in_regb),
        .in_is_immediate (in_ctrl.is_immediate),
        .out_valid       (out_valid),
        .out_regd        (out_regd),
        .out_mem_r_en    (out_ctrl.mem_r_en),
        .hazard          (hazard)
    );

    assign adv          = ~out_valid | out_ready;
    assign in_ready     = reset & (state == D_RUN) & ~hazard & adv & ~flush;
    assign accept       = in_valid & in_ready;
    assign hazard_stall = ((state == D_RUN) & hazard) | (state == D_BUBBLE);
    assign imm_ext      = {{(XLEN-IMM_W){in_imm[IMM_W-1]}}, in_imm};

`ifdef DECODE_WB_BYPASS_EN
    always_comb begin
        rega_cap = in_rega_data;
        regb_cap = in_regb_data;
        if (wb_en && (wb_regd != '0) && (wb_regd == in_rega)) rega_cap = wb_data;
        if (wb_en && (wb_regd != '0) && (wb_regd == in_regb)) regb_cap = wb_data;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_en, wb_regd, wb_data};
    assign rega_cap  = in_rega_data;
    assign regb_cap  = in_regb_data;
`endif

    // The first bubble is the slot cleared when the load leaves; BUBBLE holds
    // for the remaining LOAD_USE_BUBBLES-1 cycles.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            state         <= D_RUN;
            bub_cnt       <= '0;
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_rega_data <= '0;
            out_regb_data <= '0;
            out_imm       <= '0;
            out_rega      <= '0;
            out_regb      <= '0;
            out_regd      <= '0;
            out_ctrl      <= CTRL_NOP;
        end else begin
            unique case (state)
                D_RUN: begin
                    if (hazard) begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            out_ctrl  <= CTRL_NOP;
                            bub_cnt   <= BUB_RELOAD;
                            if (BUB_RELOAD != '0) state <= D_BUBBLE;
                        end
                    end else if (accept) begin
                        out_valid     <= 1'b1;
                        out_pc        <= in_pc;
                        out_rega_data <= rega_cap;
                        out_regb_data <= regb_cap;
                        out_imm       <= imm_ext;
                        out_rega      <= in_rega;
                        out_regb      <= in_regb;
                        out_regd      <= in_regd;
                        out_ctrl      <= in_ctrl;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                D_BUBBLE: begin
                    out_valid <= 1'b0;
                    if (bub_cnt <= BUB_ONE) begin
                        bub_cnt <= '0;
                        state   <= D_RUN;
                    end else begin
                        bub_cnt <= bub_cnt - BUB_ONE;
                    end
                end
                default: state <= D_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed bench for decode_pipe_stage with LOAD_USE_BUBBLES=2; bypass
// expectations follow DECODE_WB_BYPASS_EN.
module tb_decode_pipe_stage;
    import decode_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_rega_data;
    logic [31:0] in_regb_data;
    logic [15:0] in_imm;
    logic [4:0]  in_rega;
    logic [4:0]  in_regb;
    logic [4:0]  in_regd;
    ctrl_t       in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rega_data;
    logic [31:0] out_regb_data;
    logic [31:0] out_imm;
    logic [4:0]  out_rega;
    logic [4:0]  out_regb;
    logic [4:0]  out_regd;
    ctrl_t       out_ctrl;
    logic        hazard_stall;
    logic        wb_en;
    logic [4:0]  wb_regd;
    logic [31:0] wb_data;

    int total;
    int bad;

    decode_pipe_stage #(
        .XLEN             (32),
        .REG_IDX_W        (5),
        .IMM_W            (16),
        .LOAD_USE_BUBBLES (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_rega_data  (in_rega_data),
        .in_regb_data  (in_regb_data),
        .in_imm        (in_imm),
        .in_rega       (in_rega),
        .in_regb       (in_regb),
        .in_regd       (in_regd),
        .in_ctrl       (in_ctrl),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_rega_data (out_rega_data),
        .out_regb_data (out_regb_data),
        .out_imm       (out_imm),
        .out_rega      (out_rega),
        .out_regb      (out_regb),
        .out_regd      (out_regd),
        .out_ctrl      (out_ctrl),
        .hazard_stall  (hazard_stall),
        .wb_en         (wb_en),
        .wb_regd       (wb_regd),
        .wb_data       (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1);
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [4:0] ra,
                                 input logic [4:0] rb, input logic [4:0] rd, input logic [15:0] imm,
                                 input ctrl_t c, input logic [31:0] da, input logic [31:0] db);
        in_valid     = v;
        in_pc        = pc;
        in_rega      = ra;
        in_regb      = rb;
        in_regd      = rd;
        in_imm       = imm;
        in_ctrl      = c;
        in_rega_data = da;
        in_regb_data = db;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    ctrl_t       cPass, c2, cLd, cAdd, cImm;
    int          stallCycles, idleCycles, acceptCycle;
    logic [31:0] expByp;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        wb_en   = 1'b0;
        wb_regd = '0;
        wb_data = '0;

        cPass = CTRL_NOP; cPass.mem_w_en = 1'b1;
        c2    = CTRL_NOP; c2.wb_en = 1'b1; c2.alu_op = ALU_OP_FUNCT; c2.funct = 6'h20;
        cLd   = CTRL_NOP; cLd.mem_r_en = 1'b1; cLd.wb_en = 1'b1; cLd.mem_to_reg = 1'b1; cLd.is_immediate = 1'b1;
        cAdd  = CTRL_NOP; cAdd.wb_en = 1'b1; cAdd.alu_reg_dest = 1'b1; cAdd.alu_op = ALU_OP_ADD;
        cImm  = CTRL_NOP; cImm.is_immediate = 1'b1; cImm.alu_op = ALU_OP_SUB;

        // reset held for two cycles with a valid input present
        applyStimulus(1'b1, 32'h104, 5'd1, 5'd2, 5'd7, 16'hFFF0, cPass, 32'h11, 32'h22);
        #1 checkOutput("reset_in_ready_early", in_ready, 0);
        tick();
        tick();
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_ctrl", out_ctrl, 0);
        checkOutput("reset_out_pc", out_pc, 0);
        checkOutput("reset_in_ready", in_ready, 0);
        reset = 1'b1;
        #1 checkOutput("release_in_ready", in_ready, 1);
        tick();
        checkOutput("pass_valid", out_valid, 1);
        checkOutput("pass_imm", out_imm, 32'hFFFFFFF0);
        checkOutput("pass_pc", out_pc, 32'h104);
        checkOutput("pass_mem_w_en", out_ctrl.mem_w_en, 1);
        checkOutput("pass_rega_data", out_rega_data, 32'h11);
        checkOutput("pass_regd", out_regd, 7);

        // backpressure for three cycles
        applyStimulus(1'b1, 32'h200, 5'd3, 5'd4, 5'd8, 16'h0012, c2, 32'h33, 32'h44);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 checkOutput("bp_in_ready", in_ready, 0);
            tick();
            checkOutput("bp_hold_pc", out_pc, 32'h104);
            checkOutput("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1 checkOutput("bp_release_ready", in_ready, 1);
        tick();
        checkOutput("bp_next_pc", out_pc, 32'h200);
        checkOutput("bp_next_imm", out_imm, 32'h12);
        checkOutput("bp_next_ctrl", out_ctrl, c2);
        checkOutput("bp_next_regb_data", out_regb_data, 32'h44);
        in_valid = 1'b0;
        tick();
        checkOutput("bp_drain_valid", out_valid, 0);

        // load-use with two bubbles
        applyStimulus(1'b1, 32'h300, 5'd1, 5'd2, 5'd5, 16'h0004, cLd, 32'h0, 32'h0);
        tick();
        checkOutput("lu_load_held", out_valid, 1);
        applyStimulus(1'b1, 32'h304, 5'd5, 5'd6, 5'd9, 16'h0000, cAdd, 32'h55, 32'h66);
        stallCycles = 0;
        idleCycles  = 0;
        acceptCycle = 0;
        for (int cyc = 1; cyc <= 6 && acceptCycle == 0; cyc++) begin
            #1;
            if (hazard_stall) stallCycles++;
            if (!out_valid) idleCycles++;
            if (in_ready) acceptCycle = cyc;
            tick();
        end
        checkOutput("lu_stall_cycles", stallCycles, 2);
        checkOutput("lu_bubble_cycles", idleCycles, 2);
        checkOutput("lu_accept_cycle", acceptCycle, 3);
        checkOutput("lu_user_pc", out_pc, 32'h304);
        checkOutput("lu_user_valid", out_valid, 1);

        // load to r0 never stalls
        applyStimulus(1'b1, 32'h400, 5'd1, 5'd2, 5'd0, 16'h0000, cLd, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b1, 32'h404, 5'd0, 5'd0, 5'd3, 16'h0000, cAdd, 32'h77, 32'h88);
        #1 checkOutput("r0_no_stall", hazard_stall, 0);
        checkOutput("r0_in_ready", in_ready, 1);
        tick();
        checkOutput("r0_user_pc", out_pc, 32'h404);

        // flush together with a hazard: nothing captured, slot cleared
        applyStimulus(1'b1, 32'h500, 5'd1, 5'd2, 5'd7, 16'h0000, cLd, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b1, 32'h504, 5'd7, 5'd2, 5'd9, 16'h0000, cAdd, 32'h0, 32'h0);
        flush = 1'b1;
        #1 checkOutput("flush_in_ready", in_ready, 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_valid", out_valid, 0);
        checkOutput("flush_ctrl", out_ctrl, 0);
        checkOutput("flush_pc", out_pc, 0);
        checkOutput("flush_regd", out_regd, 0);
        #1 checkOutput("flush_no_stall", hazard_stall, 0);
        in_valid = 1'b1;
        #1 checkOutput("flush_run_ready", in_ready, 1);
        tick();
        checkOutput("flush_after_pc", out_pc, 32'h504);

        // writeback bypass on rega only
`ifdef DECODE_WB_BYPASS_EN
        expByp = 32'hDEAD;
`else
        expByp = 32'h0;
`endif
        wb_en   = 1'b1;
        wb_regd = 5'd3;
        wb_data = 32'hDEAD;
        applyStimulus(1'b1, 32'h600, 5'd3, 5'd4, 5'd2, 16'h0000, cAdd, 32'h0, 32'h55);
        tick();
        checkOutput("byp_rega_data", out_rega_data, expByp);
        checkOutput("byp_regb_data", out_regb_data, 32'h55);
        wb_regd = 5'd0;
        applyStimulus(1'b1, 32'h604, 5'd0, 5'd4, 5'd2, 16'h0000, cAdd, 32'h99, 32'h56);
        tick();
        checkOutput("byp_r0_rega_data", out_rega_data, 32'h99);
        wb_en = 1'b0;

        // reset during BUBBLE aborts the stall
        applyStimulus(1'b1, 32'h700, 5'd1, 5'd2, 5'd10, 16'h0000, cLd, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b1, 32'h704, 5'd10, 5'd2, 5'd3, 16'h0000, cAdd, 32'h0, 32'h0);
        tick();
        checkOutput("rb_in_bubble", hazard_stall, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1 checkOutput("rb_no_stall", hazard_stall, 0);
        checkOutput("rb_in_ready", in_ready, 1);
        checkOutput("rb_valid", out_valid, 0);
        tick();
        checkOutput("rb_user_pc", out_pc, 32'h704);

        // regb match ignored for immediate forms
        applyStimulus(1'b1, 32'h800, 5'd1, 5'd2, 5'd12, 16'h0000, cLd, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b1, 32'h804, 5'd1, 5'd12, 5'd3, 16'h7FFF, cImm, 32'h0, 32'h0);
        #1 checkOutput("imm_no_stall", hazard_stall, 0);
        tick();
        checkOutput("imm_pos_ext", out_imm, 32'h00007FFF);
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_pipe_stage.md
Name: decode_pipe_stage

Overview:
- Parametrised decode-to-execute pipeline stage register.
- Captures the decoded operands, immediate, register indices and control bundle into a single output slot.
- Uses a valid/ready handshake on both sides instead of a bare enable.
- Detects load-use hazards against the instruction it holds, then inserts a configurable number of bubbles while holding the upstream fetch/decode.
- Sits between the control/register-file logic and the ALU stage.

Parameters:
- XLEN, 32, datapath width of the operands, PC and sign-extended immediate.
- REG_IDX_W, 5, register index width.
- IMM_W, 16, raw immediate width; sign-extended to XLEN.
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (1..3).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  reset, synchronous, active-low.
- flush  in  1  kill the slot contents (branch taken).
- in_valid  in  1  upstream has a decoded instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  XLEN  PC+4 of the instruction.
- in_rega_data, in_regb_data  in  XLEN  register-file read data.
- in_imm  in  IMM_W  raw immediate field.
- in_rega, in_regb, in_regd  in  REG_IDX_W  source and destination indices.
- in_ctrl  in  ctrl_t  control bundle: wb_en, mem_r_en, mem_w_en, mem_to_reg, alu_reg_dest, is_branch, is_immediate, alu_op[1:0], funct[5:0].
- out_valid  out  1  slot holds a real instruction.
- out_ready  in  1  ALU stage consumes the slot this cycle.
- out_pc, out_rega_data, out_regb_data, out_imm  out  XLEN  registered payload; out_imm is sign-extended.
- out_rega, out_regb, out_regd  out  REG_IDX_W  registered indices.
- out_ctrl  out  ctrl_t  registered control.
- hazard_stall  out  1  load-use stall is active (combinational).
- wb_en, wb_regd, wb_data  in  1/REG_IDX_W/XLEN  writeback port, used only with the optional feature.

Behaviour:
- Reset (reset==0 at the edge): every out_* cleared to 0, including out_valid and all ctrl fields. State goes to RUN, bubble counter to 0. Reset overrides flush and the handshake.
- Slot advance: adv = ~out_valid | out_ready.
- Hazard condition, all of the following:
  - in_valid & out_valid & out_ctrl.mem_r_en;
  - out_regd != 0;
  - out_regd == in_rega, or (out_regd == in_regb and in_ctrl.is_immediate == 0).
- in_ready = state==RUN & ~hazard & adv & ~flush.
- Accept when in_valid & in_ready: all payload fields are captured in the same edge, including mem_w_en. Latency is 1 cycle from input to output.
- out_valid update:
  - No accept and out_ready==1: out_valid<=0, payload holds.
  - No accept and out_ready==0: slot holds unchanged.
- States: RUN and BUBBLE.
  - RUN, hazard & out_ready: the load leaves; the slot loads a bubble (out_valid<=0, ctrl cleared); the counter loads LOAD_USE_BUBBLES-1; go to BUBBLE if that value is >0, else stay in RUN.
  - RUN, hazard & ~out_ready: hold the load, in_ready=0, no bubble counted yet.
  - BUBBLE: in_ready=0, out_valid stays 0, the counter decrements each cycle, return to RUN when the counter is 0 at the edge.
- hazard_stall = (state==RUN & hazard) | state==BUBBLE.
- Flush (reset deasserted): out_valid<=0, payload and ctrl cleared to 0, state RUN, counter 0. Any upstream input that cycle is dropped. Flush beats hazard and accept in the same cycle.
- Sign extension: out_imm = {{(XLEN-IMM_W){in_imm[IMM_W-1]}}, in_imm}.
- Register 0 never participates in hazard or bypass matching.
- Reset asserted mid-BUBBLE aborts the bubble sequence with no residual stall.

Optional Feature:
- Macro DECODE_WB_BYPASS_EN.
- Defined: on accept, if wb_en & wb_regd!=0 & wb_regd==in_rega, out_rega_data captures wb_data instead of in_rega_data; the same rule applies independently to regb. Bypass happens in the same edge with no extra latency.
- Undefined: the wb_* ports exist but are ignored, and the register-file data is captured as-is.

Decomposition:
- Package decode_pkg holds:
  - ctrl_t packed struct (field order as listed under in_ctrl);
  - alu_op constants ALU_OP_ADD/SUB/FUNCT/BR;
  - state enum dstate_t {D_RUN, D_BUBBLE};
  - CTRL_NOP constant (all zero).
- Sub-module decode_hazard_unit: combinational, takes out_* indices/ctrl and in_* indices/ctrl, produces hazard. Instantiated once.

Test Plan:
- Reset: drive reset=0 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl==0, in_ready=0 during reset, and in_ready=1 on the first cycle after release.
- Pass-through: accept in_imm=16'hFFF0, in_pc=32'h104, in_ctrl.mem_w_en=1 with out_ready=1 -> next cycle out_imm=32'hFFFFFFF0, out_pc=32'h104, out_ctrl.mem_w_en=1, out_valid=1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and the slot stays constant. out_ready=1 on the 4th cycle -> the next instruction appears one cycle later with nothing lost or duplicated.
- Load-use, LOAD_USE_BUBBLES=2: slot holds a load with regd=5, and the next instruction has rega=5.
  - Required: hazard_stall=1 for 2 cycles, out_valid=0 for 2 cycles, and the instruction is accepted on the 3rd cycle.
  - Same case with regd=0: no stall.
- Flush priority: assert flush in the same cycle as an accept and as a hazard -> out_valid=0, ctrl cleared, state RUN, and the input is not captured.
- Bypass (DECODE_WB_BYPASS_EN defined): wb_en=1, wb_regd=3, wb_data=32'hDEAD, in_rega=3, in_rega_data=0 -> out_rega_data=32'hDEAD. With the macro undefined -> out_rega_data=0.
